multicycle_control: RTL and testbench

//  Main control FSM for the multi-cycle MIPS datapath. Decodes opcode and sequences one instruction

---
 rtl/mips_ctrl_pkg.sv | 44 ++++
 rtl/mem_wait_timer.sv | 38 +++
 rtl/multicycle_control.sv | 170 +++++++++++++++++
 tb/tb_multicycle_control.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS control path: opcodes, FSM states and datapath mux codes.
// Used by the multi-cycle controller, ALU control and single-cycle decoder.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam int unsigned StateW = 4;

  typedef enum logic [StateW-1:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StRwb    = 4'd7,
    StBranch = 4'd8,
    StJump   = 4'd9
  } state_e;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  localparam logic [1:0] SrcBRt     = 2'b00;
  localparam logic [1:0] SrcBFour   = 2'b01;
  localparam logic [1:0] SrcBImm    = 2'b10;
  localparam logic [1:0] SrcBImmSh2 = 2'b11;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  // States that stall on the memory handshake.
  function automatic logic is_mem_wait_state(state_e s);
    return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts stalled memory cycles; expire fires on the WAIT_LIMIT-th consecutive stalled cycle.
// WAIT_LIMIT = 0 disables expiry entirely.
module mem_wait_timer #(
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expire
);

  localparam int unsigned CntW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);
  localparam bit Enabled = (WAIT_LIMIT > 0);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en && Enabled) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = Enabled && count_en && (cnt_q == LastCnt);

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences fetch, decode, execute/memory
// and write-back, with a bounded wait on the memory ready handshake.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 16,
  parameter int unsigned STATE_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pcwrite,
  output logic               pcwritecond,
  output logic               iord,
  output logic               memread,
  output logic               memwrite,
  output logic               irwrite,
  output logic               memtoreg,
  output logic               regdst,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         aluop,
  output logic [1:0]         pcsource,
  output logic [STATE_W-1:0] state,
  output logic               instr_done,
  output logic               illegal_op,
  output logic               mem_timeout
);

  state_e state_q, state_d;
  logic   done_q, done_d;
  logic   timer_clear, timer_expire;

  mem_wait_timer #(
    .WAIT_LIMIT(WAIT_LIMIT)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .count_en(is_mem_wait_state(state_q) && !mem_ready),
    .expire  (timer_expire)
  );

  assign mem_timeout = timer_expire;
  assign timer_clear = (state_d != state_q) || timer_expire;

  // Next-state; a timeout always abandons the instruction back to FETCH.
  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    illegal_op = 1'b0;
    unique case (state_q)
      StFetch: begin
        if (mem_ready) state_d = StDecode;
        else if (timer_expire) state_d = StFetch;
      end
      StDecode: begin
        case (opcode)
          OP_LW, OP_SW: state_d = StMemAdr;
          OP_RTYPE:     state_d = StExec;
          OP_BEQ:       state_d = StBranch;
          OP_J:         state_d = StJump;
          default: begin
            state_d    = StFetch;
            illegal_op = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        if (opcode == OP_LW) state_d = StMemRd;
        else if (opcode == OP_SW) state_d = StMemWr;
        else state_d = StFetch;
      end
      StMemRd: begin
        if (mem_ready) state_d = StMemWb;
        else if (timer_expire) state_d = StFetch;
      end
      StMemWr: begin
        if (mem_ready) begin
          state_d = StFetch;
          done_d  = 1'b1;
        end else if (timer_expire) begin
          state_d = StFetch;
        end
      end
      StExec: state_d = StRwb;
      StMemWb, StRwb, StBranch, StJump: begin
        state_d = StFetch;
        done_d  = 1'b1;
      end
      default: state_d = StFetch;
    endcase
  end

  always_comb begin
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = SrcBRt;
    aluop       = AluOpAdd;
    pcsource    = PcSrcAlu;
    unique case (state_q)
      StFetch: begin
        memread = 1'b1;
        alusrcb = SrcBFour;
        irwrite = mem_ready;
        pcwrite = mem_ready;
      end
      StDecode: alusrcb = SrcBImmSh2;
      StMemAdr: begin
        alusrca = 1'b1;
        alusrcb = SrcBImm;
      end
      StMemRd: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      StMemWb: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      StMemWr: begin
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      StExec: begin
        alusrca = 1'b1;
        aluop   = AluOpFunct;
      end
      StRwb: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      StBranch: begin
        alusrca     = 1'b1;
        aluop       = AluOpSub;
        pcwritecond = 1'b1;
        pcsource    = PcSrcAluOut;
      end
      StJump: begin
        pcwrite  = 1'b1;
        pcsource = PcSrcJump;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StFetch;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  assign instr_done = done_q;
  assign state      = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboarded bench for multicycle_control: per-cycle expected state, control vector and
// pulses are queued as stimulus is driven and popped when the outputs are sampled.
module tb_multicycle_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
  logic       memtoreg, regdst, regwrite, alusrca;
  logic [1:0] alusrcb, aluop, pcsource;
  logic [3:0] state;
  logic       instr_done, illegal_op, mem_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] ctrl;
    logic [2:0]  pls;
  } exp_t;

  exp_t sb[$];

  logic [15:0] act_ctrl;
  logic [2:0]  act_pls;
  assign act_ctrl = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, regdst,
                     regwrite, alusrca, alusrcb, aluop, pcsource};
  assign act_pls  = {instr_done, illegal_op, mem_timeout};

  multicycle_control #(
    .WAIT_LIMIT(4),
    .STATE_W   (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .pcwrite    (pcwrite),
    .pcwritecond(pcwritecond),
    .iord       (iord),
    .memread    (memread),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .memtoreg   (memtoreg),
    .regdst     (regdst),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .aluop      (aluop),
    .pcsource   (pcsource),
    .state      (state),
    .instr_done (instr_done),
    .illegal_op (illegal_op),
    .mem_timeout(mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference control table, bit order matches act_ctrl.
  function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic mr);
    logic       pcw, pcwc, ird, mrd, mwr, irw, m2r, rdst, rw, srca;
    logic [1:0] srcb, aop, psrc;
    {pcw, pcwc, ird, mrd, mwr, irw, m2r, rdst, rw, srca} = '0;
    srcb = 2'b00;
    aop  = 2'b00;
    psrc = 2'b00;
    case (st)
      4'd0: begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
      4'd1: srcb = 2'b11;
      4'd2: begin srca = 1; srcb = 2'b10; end
      4'd3: begin mrd = 1; ird = 1; end
      4'd4: begin rw = 1; m2r = 1; end
      4'd5: begin mwr = 1; ird = 1; end
      4'd6: begin srca = 1; aop = 2'b10; end
      4'd7: begin rw = 1; rdst = 1; end
      4'd8: begin srca = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
      4'd9: begin pcw = 1; psrc = 2'b10; end
      default: ;
    endcase
    return {pcw, pcwc, ird, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aop, psrc};
  endfunction

  task automatic test_reset();
    exp_t e;
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    opcode    = 6'b000000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back('{st: 4'd0, ctrl: exp_ctrl(4'd0, 1'b0), pls: 3'b000});
    #1;
    e = sb.pop_front();
    n_tests++;
    if (state !== e.st) begin
      n_fail++;
      $display("FAIL reset state: got %0d want %0d", state, e.st);
    end
    n_tests++;
    if (act_ctrl !== e.ctrl) begin
      n_fail++;
      $display("FAIL reset ctrl: got %b want %b", act_ctrl, e.ctrl);
    end
    n_tests++;
    if (act_pls !== e.pls) begin
      n_fail++;
      $display("FAIL reset pulses: got %b want %b", act_pls, e.pls);
    end
    @(negedge clk);
  endtask

  task automatic test_rtype();
    logic [3:0] st_l[5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    bit         mr_l[5] = '{1, 1, 1, 1, 0};
    logic [2:0] pl_l[5] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b100};
    exp_t e;
    opcode = 6'b000000;
    for (int i = 0; i < 5; i++) begin
      mem_ready = mr_l[i];
      sb.push_back('{st: st_l[i], ctrl: exp_ctrl(st_l[i], mr_l[i]), pls: pl_l[i]});
      #1;
      e = sb.pop_front();
      n_tests++;
      if (state !== e.st) begin
        n_fail++;
        $display("FAIL rtype[%0d] state: got %0d want %0d", i, state, e.st);
      end
      n_tests++;
      if (act_ctrl !== e.ctrl) begin
        n_fail++;
        $display("FAIL rtype[%0d] ctrl: got %b want %b", i, act_ctrl, e.ctrl);
      end
      n_tests++;
      if (act_pls !== e.pls) begin
        n_fail++;
        $display("FAIL rtype[%0d] pulses: got %b want %b", i, act_pls, e.pls);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lw_wait();
    logic [3:0] st_l[9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
    bit         mr_l[9] = '{1, 0, 0, 0, 0, 0, 1, 0, 0};
    exp_t e;
    opcode = 6'b100011;
    for (int i = 0; i < 9; i++) begin
      mem_ready = mr_l[i];
      sb.push_back('{st: st_l[i], ctrl: exp_ctrl(st_l[i], mr_l[i]),
                     pls: (i == 8) ? 3'b100 : 3'b000});
      #1;
      e = sb.pop_front();
      n_tests++;
      if (state !== e.st) begin
        n_fail++;
        $display("FAIL lw[%0d] state: got %0d want %0d", i, state, e.st);
      end
      n_tests++;
      if (act_ctrl !== e.ctrl) begin
        n_fail++;
        $display("FAIL lw[%0d] ctrl: got %b want %b", i, act_ctrl, e.ctrl);
      end
      n_tests++;
      if (act_pls !== e.pls) begin
        n_fail++;
        $display("FAIL lw[%0d] pulses: got %b want %b", i, act_pls, e.pls);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_sw();
    logic [3:0] st_l[5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    bit         mr_l[5] = '{1, 0, 0, 1, 0};
    exp_t e;
    opcode = 6'b101011;
    for (int i = 0; i < 5; i++) begin
      mem_ready = mr_l[i];
      sb.push_back('{st: st_l[i], ctrl: exp_ctrl(st_l[i], mr_l[i]),
                     pls: (i == 4) ? 3'b100 : 3'b000});
      #1;
      e = sb.pop_front();
      n_tests++;
      if (state !== e.st) begin
        n_fail++;
        $display("FAIL sw[%0d] state: got %0d want %0d", i, state, e.st);
      end
      n_tests++;
      if (act_ctrl !== e.ctrl) begin
        n_fail++;
        $display("FAIL sw[%0d] ctrl: got %b want %b", i, act_ctrl, e.ctrl);
      end
      n_tests++;
      if (act_pls !== e.pls) begin
        n_fail++;
        $display("FAIL sw[%0d] pulses: got %b want %b", i, act_pls, e.pls);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] st_l[7] = '{4'd0, 4'd1, 4'd8, 4'd0, 4'd1, 4'd9, 4'd0};
    bit         mr_l[7] = '{1, 0, 0, 1, 0, 0, 0};
    logic [2:0] pl_l[7] = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b000, 3'b000, 3'b100};
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      mem_ready = mr_l[i];
      opcode    = (i < 3) ? 6'b000100 : 6'b000010;
      sb.push_back('{st: st_l[i], ctrl: exp_ctrl(st_l[i], mr_l[i]), pls: pl_l[i]});
      #1;
      e = sb.pop_front();
      n_tests++;
      if (state !== e.st) begin
        n_fail++;
        $display("FAIL beq_j[%0d] state: got %0d want %0d", i, state, e.st);
      end
      n_tests++;
      if (act_ctrl !== e.ctrl) begin
        n_fail++;
        $display("FAIL beq_j[%0d] ctrl: got %b want %b", i, act_ctrl, e.ctrl);
      end
      n_tests++;
      if (act_pls !== e.pls) begin
        n_fail++;
        $display("FAIL beq_j[%0d] pulses: got %b want %b", i, act_pls, e.pls);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    logic [3:0] st_l[3] = '{4'd0, 4'd1, 4'd0};
    bit         mr_l[3] = '{1, 0, 0};
    logic [2:0] pl_l[3] = '{3'b000, 3'b010, 3'b000};
    exp_t e;
    opcode = 6'b111111;
    for (int i = 0; i < 3; i++) begin
      mem_ready = mr_l[i];
      sb.push_back('{st: st_l[i], ctrl: exp_ctrl(st_l[i], mr_l[i]), pls: pl_l[i]});
      #1;
      e = sb.pop_front();
      n_tests++;
      if (state !== e.st) begin
        n_fail++;
        $display("FAIL illegal[%0d] state: got %0d want %0d", i, state, e.st);
      end
      n_tests++;
      if (act_ctrl !== e.ctrl) begin
        n_fail++;
        $display("FAIL illegal[%0d] ctrl: got %b want %b", i, act_ctrl, e.ctrl);
      end
      n_tests++;
      if (act_pls !== e.pls) begin
        n_fail++;
        $display("FAIL illegal[%0d] pulses: got %b want %b", i, act_pls, e.pls);
      end
      @(negedge clk);
    end
  endtask

  // Timeout in FETCH, ready-on-limit-cycle completion, then timeout in MEMWR.
  task automatic test_timeout();
    logic [3:0] st_l[16] = '{4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0,
                             4'd0, 4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5};
    bit         mr_l[16] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    logic [2:0] pl;
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      mem_ready = mr_l[i];
      opcode    = (i < 2) ? 6'b111111 : 6'b101011;
      pl        = (i == 1) ? 3'b010 : ((i == 5 || i == 15) ? 3'b001 : 3'b000);
      sb.push_back('{st: st_l[i], ctrl: exp_ctrl(st_l[i], mr_l[i]), pls: pl});
      #1;
      e = sb.pop_front();
      n_tests++;
      if (state !== e.st) begin
        n_fail++;
        $display("FAIL timeout[%0d] state: got %0d want %0d", i, state, e.st);
      end
      n_tests++;
      if (act_ctrl !== e.ctrl) begin
        n_fail++;
        $display("FAIL timeout[%0d] ctrl: got %b want %b", i, act_ctrl, e.ctrl);
      end
      n_tests++;
      if (act_pls !== e.pls) begin
        n_fail++;
        $display("FAIL timeout[%0d] pulses: got %b want %b", i, act_pls, e.pls);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] st_l[5]  = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    bit         mr_l[5]  = '{1, 0, 0, 0, 0};
    bit         rst_l[5] = '{1, 1, 1, 0, 1};
    exp_t e;
    opcode = 6'b101011;
    for (int i = 0; i < 5; i++) begin
      mem_ready = mr_l[i];
      rst_n     = rst_l[i];
      sb.push_back('{st: st_l[i], ctrl: exp_ctrl(st_l[i], mr_l[i]), pls: 3'b000});
      #1;
      e = sb.pop_front();
      n_tests++;
      if (state !== e.st) begin
        n_fail++;
        $display("FAIL rstmid[%0d] state: got %0d want %0d", i, state, e.st);
      end
      n_tests++;
      if (act_ctrl !== e.ctrl) begin
        n_fail++;
        $display("FAIL rstmid[%0d] ctrl: got %b want %b", i, act_ctrl, e.ctrl);
      end
      n_tests++;
      if (act_pls !== e.pls) begin
        n_fail++;
        $display("FAIL rstmid[%0d] pulses: got %b want %b", i, act_pls, e.pls);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_sw();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
